// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_align
//  Brief    : Load/store alignment unit in front of a 4-lane byte-writable,
//             word-addressed data memory with one-cycle registered read.
//             Stores: lane replication and byte write mask.
//             Loads : lane extraction with sign/zero extension.
//  Options  : LSU_MISALIGN_TRAP_EN - when defined, misaligned half/word
//             accesses are not performed and respond with resp_err=1.
//             When undefined, misaligned low address bits are cleared.
//  Revision : 1.0 - initial release
// ============================================================================
module lsu_align #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W+1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] MemAddress,
  output logic [31:0]       MemWriteData,
  output logic [3:0]        MemWriteMask,
  input  logic [31:0]       MemReadData
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t      state;
  state_t      state_next;

  // Request fields latched in the accepting cycle
  logic        lat_we;
  logic [1:0]  lat_size;
  logic        lat_unsigned;
  logic [1:0]  lat_off;
  logic        lat_err;

  // Decode of the incoming request
  logic        size_half;
  logic        size_word;
  logic [1:0]  eff_off;
  logic        misalign;
  logic [31:0] store_data;
  logic [3:0]  store_mask;

  // Load extraction
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_data;

  assign size_half = (req_size == 2'b01);
  assign size_word = req_size[1];

  // Effective lane offset, misalignment detection, store data/mask generation
  always_comb begin
    eff_off  = req_addr[1:0];
    misalign = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    if (size_word) begin
      misalign = |req_addr[1:0];
    end else if (size_half) begin
      misalign = req_addr[0];
    end
`else
    if (size_word) begin
      eff_off = 2'b00;
    end else if (size_half) begin
      eff_off[0] = 1'b0;
    end
`endif
    if (size_word) begin
      store_data = req_wdata;
      store_mask = 4'b1111;
    end else if (size_half) begin
      store_data = {2{req_wdata[15:0]}};
      store_mask = 4'b0011 << {eff_off[1], 1'b0};
    end else begin
      store_data = {4{req_wdata[7:0]}};
      store_mask = 4'b0001 << eff_off;
    end
    // Loads and trapped accesses never write memory
    if (!req_we || misalign) begin
      store_mask = 4'b0000;
    end
  end

  // Select the addressed lane(s) of the returned word and extend
  always_comb begin
    case (lat_off)
      2'd0:    load_byte = MemReadData[7:0];
      2'd1:    load_byte = MemReadData[15:8];
      2'd2:    load_byte = MemReadData[23:16];
      default: load_byte = MemReadData[31:24];
    endcase
    load_half = lat_off[1] ? MemReadData[31:16] : MemReadData[15:0];
    if (lat_size[1]) begin
      load_data = MemReadData;
    end else if (lat_size == 2'b01) begin
      load_data = {{16{load_half[15] & ~lat_unsigned}}, load_half};
    end else begin
      load_data = {{24{load_byte[7] & ~lat_unsigned}}, load_byte};
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and handshake outputs
  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_next = (lat_we || lat_err) ? S_RESP : S_WAIT;
      end
      S_WAIT: begin
        state_next = S_RESP;
      end
      default: begin
        resp_valid = 1'b1;
        state_next = S_IDLE;
      end
    endcase
  end

  // Request latch, registered memory port and response data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_we       <= 1'b0;
      lat_size     <= 2'b00;
      lat_unsigned <= 1'b0;
      lat_off      <= 2'b00;
      lat_err      <= 1'b0;
      MemAddress   <= '0;
      MemWriteData <= 32'd0;
      MemWriteMask <= 4'b0000;
      resp_rdata   <= 32'd0;
      resp_err     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            lat_we       <= req_we;
            lat_size     <= req_size;
            lat_unsigned <= req_unsigned;
            lat_off      <= eff_off;
            lat_err      <= misalign;
            MemAddress   <= req_addr[ADDR_W+1:2];
            MemWriteData <= store_data;
            MemWriteMask <= store_mask;
          end
        end
        S_ISSUE: begin
          MemWriteMask <= 4'b0000;
          // Stores and trapped accesses respond straight after ISSUE
          if (lat_we || lat_err) begin
            resp_rdata <= 32'd0;
            resp_err   <= lat_err;
          end
        end
        S_WAIT: begin
          resp_rdata <= load_data;
          resp_err   <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lsu_align.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lsu_align
//  Brief    : Self-checking bench for lsu_align with a byte-writable,
//             registered-read memory model and a response scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_align;
  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [1:0]        req_size = 2'b00;
  logic              req_unsigned = 1'b0;
  logic [ADDR_W+1:0] req_addr = '0;
  logic [31:0]       req_wdata = 32'd0;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic [ADDR_W-1:0] MemAddress;
  logic [31:0]       MemWriteData;
  logic [3:0]        MemWriteMask;
  logic [31:0]       MemReadData = 32'd0;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          cyc;
  } exp_t;
  exp_t exp_q[$];

  logic [31:0] mem [0:(1<<ADDR_W)-1];

  lsu_align #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .MemAddress(MemAddress), .MemWriteData(MemWriteData),
    .MemWriteMask(MemWriteMask), .MemReadData(MemReadData)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: read-first registered read, per-byte write
  initial begin
    for (int i = 0; i < (1<<ADDR_W); i++) mem[i] = 32'd0;
  end
  always @(posedge clk) begin
    MemReadData <= mem[MemAddress];
    for (int i = 0; i < 4; i++)
      if (MemWriteMask[i]) mem[MemAddress][8*i +: 8] <= MemWriteData[8*i +: 8];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every response
  always @(negedge clk) begin
    if (resp_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: got resp_valid=1 expected none (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("resp_rdata", resp_rdata, e.rd);
        check("resp_err", {31'd0, resp_err}, {31'd0, e.err});
        check("resp_cycle", cyc, e.cyc);
      end
    end
  end

  // Issue one request from an IDLE-waiting negedge; returns at the ISSUE negedge
  task automatic do_req(input bit we, input logic [1:0] size, input bit uns,
                        input logic [11:0] addr, input logic [31:0] wdata,
                        input bit push, input logic [31:0] exp_rd, input bit exp_err,
                        input int exp_lat, input logic [9:0] exp_ma,
                        input logic [3:0] exp_mask, input logic [31:0] exp_md);
    int n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got req_ready=0 expected 1 within 20 cycles");
    end
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    if (push) exp_q.push_back('{exp_rd, exp_err, cyc + exp_lat});
    @(negedge clk);
    req_valid = 1'b0;
    check("ready_in_issue", {31'd0, req_ready}, 32'd0);
    check("issue_addr", {22'd0, MemAddress}, {22'd0, exp_ma});
    check("issue_mask", {28'd0, MemWriteMask}, {28'd0, exp_mask});
    if (we) check("issue_wdata", MemWriteData, exp_md);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_err", {31'd0, resp_err}, 32'd0);
    check("rst_mask", {28'd0, MemWriteMask}, 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_addr", {22'd0, MemAddress}, 32'd0);
    check("rst_wdata", MemWriteData, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    //     we  size   uns addr    wdata         push exp_rd        err lat ma    mask     mdata
    do_req(1, 2'b10, 0, 12'h010, 32'hDEADBEEF, 1, 32'h00000000, 0, 2, 10'd4, 4'b1111, 32'hDEADBEEF);
    do_req(1, 2'b00, 0, 12'h013, 32'h123456A5, 1, 32'h00000000, 0, 2, 10'd4, 4'b1000, 32'hA5A5A5A5);
    do_req(0, 2'b10, 0, 12'h010, 32'h0,        1, 32'hA5ADBEEF, 0, 3, 10'd4, 4'b0000, 32'h0);
    do_req(0, 2'b00, 0, 12'h013, 32'h0,        1, 32'hFFFFFFA5, 0, 3, 10'd4, 4'b0000, 32'h0);
    do_req(0, 2'b00, 1, 12'h013, 32'h0,        1, 32'h000000A5, 0, 3, 10'd4, 4'b0000, 32'h0);
    do_req(0, 2'b01, 0, 12'h012, 32'h0,        1, 32'hFFFFA5AD, 0, 3, 10'd4, 4'b0000, 32'h0);
    do_req(0, 2'b01, 0, 12'h010, 32'h0,        1, 32'hFFFFBEEF, 0, 3, 10'd4, 4'b0000, 32'h0);
    do_req(0, 2'b00, 0, 12'h011, 32'h0,        1, 32'hFFFFFFBE, 0, 3, 10'd4, 4'b0000, 32'h0);
    do_req(0, 2'b00, 1, 12'h010, 32'h0,        1, 32'h000000EF, 0, 3, 10'd4, 4'b0000, 32'h0);
    do_req(1, 2'b01, 0, 12'h016, 32'hABCD1234, 1, 32'h00000000, 0, 2, 10'd5, 4'b1100, 32'h12341234);
    do_req(0, 2'b01, 1, 12'h016, 32'h0,        1, 32'h00001234, 0, 3, 10'd5, 4'b0000, 32'h0);
    do_req(0, 2'b10, 0, 12'h014, 32'h0,        1, 32'h12340000, 0, 3, 10'd5, 4'b0000, 32'h0);
    do_req(1, 2'b11, 0, 12'h018, 32'hCAFEF00D, 1, 32'h00000000, 0, 2, 10'd6, 4'b1111, 32'hCAFEF00D);
    do_req(0, 2'b11, 0, 12'h018, 32'h0,        1, 32'hCAFEF00D, 0, 3, 10'd6, 4'b0000, 32'h0);
    // Misaligned half load at 0x011
`ifdef LSU_MISALIGN_TRAP_EN
    do_req(0, 2'b01, 1, 12'h011, 32'h0,        1, 32'h00000000, 1, 2, 10'd4, 4'b0000, 32'h0);
`else
    do_req(0, 2'b01, 1, 12'h011, 32'h0,        1, 32'h0000BEEF, 0, 3, 10'd4, 4'b0000, 32'h0);
`endif

    // Back-to-back: req_valid held high across two requests
    while (!req_ready) @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 12'h01C; req_wdata = 32'h55667788;
    exp_q.push_back('{32'h0, 1'b0, cyc + 2});
    @(negedge clk);
    check("b2b_ready_issue", {31'd0, req_ready}, 32'd0);
    req_addr = 12'h020; req_wdata = 32'h11223344;
    @(negedge clk);
    check("b2b_ready_resp", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    check("b2b_ready_idle", {31'd0, req_ready}, 32'd1);
    exp_q.push_back('{32'h0, 1'b0, cyc + 2});
    @(negedge clk);
    req_valid = 1'b0;
    check("b2b_second_addr", {22'd0, MemAddress}, 32'd8);
    check("b2b_second_mask", {28'd0, MemWriteMask}, 32'hF);
    check("b2b_second_wdata", MemWriteData, 32'h11223344);
    do_req(0, 2'b10, 0, 12'h020, 32'h0,        1, 32'h11223344, 0, 3, 10'd8, 4'b0000, 32'h0);
    do_req(0, 2'b10, 0, 12'h01C, 32'h0,        1, 32'h55667788, 0, 3, 10'd7, 4'b0000, 32'h0);

    // Reset during ISSUE of a store: no write, no response
    do_req(1, 2'b00, 0, 12'h013, 32'h0000005A, 0, 32'h0,        0, 0, 10'd4, 4'b1000, 32'h5A5A5A5A);
    #1 rst_n = 1'b0;
    #1;
    check("abort_mask", {28'd0, MemWriteMask}, 32'd0);
    check("abort_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("abort_ready", {31'd0, req_ready}, 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_req(0, 2'b10, 0, 12'h010, 32'h0,        1, 32'hA5ADBEEF, 0, 3, 10'd4, 4'b0000, 32'h0);

    // Drain the scoreboard
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 32'd0);
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lsu_align.md
# lsu_align

Load/store alignment unit that sits directly upstream of the 4-lane byte-writable data memory and drives its word-addressed port (`MemAddress`, `MemWriteData`, `MemWriteMask`, `MemReadData`) on behalf of the core. It accepts byte-addressed load and store requests of byte, halfword or word size. For stores, it replicates write data across the byte lanes and generates the per-lane write mask. For loads, it waits out the memory's one-cycle registered read latency, then extracts, sign- or zero-extends, and returns the addressed lane(s).

## Interface
Parameters:
- `ADDR_W`, default 10: word-address width of the memory port; byte address is `ADDR_W+2` bits.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit can accept a request; high only in IDLE.
- `req_we`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 = byte, 01 = half, 10 = word, 11 = treated as word.
- `req_unsigned`  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- `req_addr`  in  `ADDR_W+2`  byte address.
- `req_wdata`  in  32  store data, right-justified.
- `resp_valid`  out  1  one-cycle response pulse; no backpressure.
- `resp_rdata`  out  32  load result; 0 for stores.
- `resp_err`  out  1  misaligned access; only when `LSU_MISALIGN_TRAP_EN` is defined.
- `MemAddress`  out  `ADDR_W`  word address, equal to `req_addr[ADDR_W+1:2]`.
- `MemWriteData`  out  32  lane-replicated store data.
- `MemWriteMask`  out  4  per-byte write enable; bit i controls bits [8i+7:8i].
- `MemReadData`  in  32  memory read data, valid one cycle after the address is captured.

## Operation
- State machine with four states: IDLE, ISSUE, WAIT, RESP. All memory-port outputs are registered.
- **IDLE:**
  - `req_ready`=1.
  - On `req_valid`, latch the request.
  - Load `MemAddress`, `MemWriteData` and `MemWriteMask` registers (mask forced to 0 for loads).
  - Go to ISSUE.
- **ISSUE:** lasts one cycle, during which the memory samples the port.
  - Clear `MemWriteMask` on exit.
  - Stores go to RESP.
  - Loads go to WAIT.
- **WAIT:** loads only.
  - Capture the aligned and extended `MemReadData` into `resp_rdata`.
  - Go to RESP.
- **RESP:**
  - `resp_valid`=1 for one cycle.
  - Return to IDLE.
  - `resp_rdata` and `resp_err` hold their value until the next response.
- Store write data and mask:
  - Byte: data `{4{wdata[7:0]}}`, mask `4'b0001 << addr[1:0]`.
  - Half: data `{2{wdata[15:0]}}`, mask `4'b0011 << {addr[1],1'b0}`.
  - Word: data `wdata`, mask `4'b1111`.
- Load extraction, using the latched `addr[1:0]`:
  - Byte: lane `addr[1:0]`.
  - Half: upper half if `addr[1]`=1, else lower half.
  - Word: all 32 bits.
  - Extension: bit 7 (byte) or bit 15 (half) replicated when `req_unsigned`=0, zeros when 1.
- `MemAddress` holds its last value outside ISSUE. Only `MemWriteMask` must be 0 outside ISSUE.
- Requests presented while `req_ready`=0 are ignored. `req_*` is sampled only in the accepting cycle.

## Timing
- Reset values:
  - State IDLE, `req_ready`=1.
  - `resp_valid`, `resp_err`, `MemWriteMask` = 0.
  - `resp_rdata`, `MemAddress`, `MemWriteData` = 0.
- Store latency: accept edge T0, ISSUE during T0→T1, `resp_valid` during T1→T2. Throughput is one store per 3 cycles.
- Load latency: accept edge T0, ISSUE T0→T1, WAIT T1→T2, `resp_valid` with data T2→T3. Throughput is one load per 4 cycles.
- `req_ready` falls in the cycle after acceptance and rises again in the cycle after RESP.
- Reset asserted mid-operation:
  - Outputs go to their reset values immediately (asynchronous).
  - A store caught in ISSUE has its mask dropped, so no partial write is guaranteed.
  - No response is produced for the aborted request.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - A half access with `addr[0]`=1, or a word access with `addr[1:0]`≠0, is misaligned.
  - A misaligned access takes the store path IDLE→ISSUE→RESP with `MemWriteMask`=0 for stores and loads alike.
  - Its response has `resp_err`=1 and `resp_rdata`=0, with 2-cycle latency.
- `LSU_MISALIGN_TRAP_EN` undefined:
  - Misaligned low address bits are silently cleared: half clears `addr[0]`, word clears `addr[1:0]`.
  - The access then proceeds normally.
  - `resp_err` is tied to 0.

## Test plan
- Store word 0xDEADBEEF at address 0x010 → during ISSUE, `MemAddress`=4, mask=1111, data=0xDEADBEEF; `resp_valid` 2 cycles after accept.
- Store byte 0xA5 at address 0x013 → mask=1000, data=0xA5A5A5A5. Then load word at 0x010 → `resp_rdata`=0xA5ADBEEF, 3 cycles after accept.
- Load byte at 0x013 signed → 0xFFFFFFA5; unsigned → 0x000000A5. Load half at 0x012 signed → 0xFFFFA5AD.
- Half load at 0x011: with the macro, `resp_err`=1, `resp_rdata`=0, no write, latency 2. Without the macro, it reads half at 0x010 → 0x0000BEEF unsigned.
- Back-to-back `req_valid` held high → `req_ready` low during ISSUE/WAIT/RESP; the second request is accepted only after returning to IDLE.
- Assert `rst_n`=0 during ISSUE of a store → mask drops to 0 immediately, no `resp_valid`. A subsequent load of that address returns the old data.
